// File: rtl/hazard_fwd_unit.sv
// Load-use hazard detection and EX/MEM/WB operand forwarding from a shadow copy of in-flight destination regs.
// Latency: selects and stop are combinational from shadow state; backpressure: stop holds PC/IF-ID and bubbles ID/EX.
module hazard_fwd_unit #(
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs1_i,
  input  logic [4:0]       rs2_i,
  input  logic             re1_i,
  input  logic             re2_i,
  input  logic [4:0]       rd_i,
  input  logic             RegWrite_i,
  input  logic             is_load_i,
  input  logic             bubble_i,
  input  logic             jump,
  output logic             case_A1,
  output logic             case_B1,
  output logic             case_C1,
  output logic             case_A2,
  output logic             case_B2,
  output logic             case_C2,
  output logic             stop,
  output logic [CNT_W-1:0] stall_cnt_o
);

  typedef struct packed {
    logic       vld;
    logic [4:0] rd;
    logic       we;
    logic       ld;
  } shd_t;

  shd_t             ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       f1, f2;
  logic             hazard;

  function automatic logic hit(input shd_t s, input logic [4:0] rs, input logic en);
    return en && s.vld && s.we && (s.rd != 5'd0) && (s.rd == rs);
  endfunction

  // Result {hazard, fwd_ex, fwd_mem, fwd_wb}. A load in stage s is only
  // usable once s >= LOAD_STALL; the youngest matching stage decides alone.
  function automatic logic [3:0] fwd(input logic [4:0] rs, input logic en,
                                     input shd_t ex, input shd_t mem, input shd_t wb);
    logic       k0, k1, k2;
    logic [3:0] r;
    k0 = ex.ld;
    k1 = mem.ld && (LOAD_STALL > 1);
    k2 = wb.ld && (LOAD_STALL > 2);
    r  = 4'b0000;
    if (hit(ex, rs, en))       r = k0 ? 4'b1000 : 4'b0100;
    else if (hit(mem, rs, en)) r = k1 ? 4'b1000 : 4'b0010;
    else if (hit(wb, rs, en))  r = k2 ? 4'b1000 : 4'b0001;
    return r;
  endfunction

  always_comb begin
    f1     = fwd(rs1_i, re1_i && !bubble_i, ex_q, mem_q, wb_q);
    f2     = fwd(rs2_i, re2_i && !bubble_i, ex_q, mem_q, wb_q);
    hazard = f1[3] | f2[3];
    // A taken jump flushes ID, so its wrong-path hazard must not stall.
    stop   = hazard & ~jump;

    {case_A1, case_B1, case_C1} = stop ? 3'b000 : f1[2:0];
    {case_A2, case_B2, case_C2} = stop ? 3'b000 : f2[2:0];

    wb_d  = mem_q;
    mem_d = ex_q;
    ex_d  = '0;
    if (!(stop || jump || bubble_i)) begin
      ex_d.vld = 1'b1;
      ex_d.rd  = rd_i;
      ex_d.we  = RegWrite_i;
      ex_d.ld  = is_load_i;
    end

    cnt_d = cnt_q;
    if (stop && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
      cnt_q <= cnt_d;
    end
  end

  assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench for hazard_fwd_unit: LOAD_STALL=1, LOAD_STALL=2 and a narrow-counter
// instance share ID stimulus; expectations are queued per step and drained at the negedge.
module tb_hazard_fwd_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs1_i, rs2_i, rd_i;
  logic       re1_i, re2_i, RegWrite_i, is_load_i, bubble_i, jump;

  // {stop, A1, B1, C1, A2, B2, C2}
  wire [6:0]  o1, o2, o3;
  wire [31:0] c1, c2;
  wire [1:0]  c3;

  always #5 clk = ~clk;

  hazard_fwd_unit #(.LOAD_STALL(1), .CNT_W(32)) dut1 (
    .clk(clk), .reset(reset), .rs1_i(rs1_i), .rs2_i(rs2_i), .re1_i(re1_i), .re2_i(re2_i),
    .rd_i(rd_i), .RegWrite_i(RegWrite_i), .is_load_i(is_load_i), .bubble_i(bubble_i), .jump(jump),
    .case_A1(o1[5]), .case_B1(o1[4]), .case_C1(o1[3]),
    .case_A2(o1[2]), .case_B2(o1[1]), .case_C2(o1[0]),
    .stop(o1[6]), .stall_cnt_o(c1));

  hazard_fwd_unit #(.LOAD_STALL(2), .CNT_W(32)) dut2 (
    .clk(clk), .reset(reset), .rs1_i(rs1_i), .rs2_i(rs2_i), .re1_i(re1_i), .re2_i(re2_i),
    .rd_i(rd_i), .RegWrite_i(RegWrite_i), .is_load_i(is_load_i), .bubble_i(bubble_i), .jump(jump),
    .case_A1(o2[5]), .case_B1(o2[4]), .case_C1(o2[3]),
    .case_A2(o2[2]), .case_B2(o2[1]), .case_C2(o2[0]),
    .stop(o2[6]), .stall_cnt_o(c2));

  hazard_fwd_unit #(.LOAD_STALL(1), .CNT_W(2)) dut3 (
    .clk(clk), .reset(reset), .rs1_i(rs1_i), .rs2_i(rs2_i), .re1_i(re1_i), .re2_i(re2_i),
    .rd_i(rd_i), .RegWrite_i(RegWrite_i), .is_load_i(is_load_i), .bubble_i(bubble_i), .jump(jump),
    .case_A1(o3[5]), .case_B1(o3[4]), .case_C1(o3[3]),
    .case_A2(o3[2]), .case_B2(o3[1]), .case_C2(o3[0]),
    .stop(o3[6]), .stall_cnt_o(c3));

  typedef struct {
    string       tag;
    int          which;
    logic [6:0]  sel;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic want(input string tag, input int which, input logic [6:0] sel, input logic [31:0] cnt);
    sb.push_back('{tag, which, sel, cnt});
  endtask

  task automatic want2(input string tag, input logic [6:0] sel, input logic [31:0] cnt1, input logic [31:0] cnt2);
    want(tag, 1, sel, cnt1);
    want(tag, 2, sel, cnt2);
  endtask

  task automatic cmp();
    exp_t        e;
    logic [6:0]  os;
    logic [31:0] oc;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.which)
        1:       begin os = o1; oc = c1; end
        2:       begin os = o2; oc = c2; end
        default: begin os = o3; oc = {30'b0, c3}; end
      endcase
      n_vec++;
      assert (os === e.sel) else begin
        n_miss++;
        $error("FAIL %s dut%0d sel observed=%b expected=%b", e.tag, e.which, os, e.sel);
      end
      n_vec++;
      assert (oc === e.cnt) else begin
        n_miss++;
        $error("FAIL %s dut%0d stall_cnt observed=%0d expected=%0d", e.tag, e.which, oc, e.cnt);
      end
    end
  endtask

  task automatic chk();
    @(negedge clk);
    cmp();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic id(input logic [4:0] r1, input logic [4:0] r2, input logic e1, input logic e2,
                    input logic [4:0] rd, input logic we, input logic ld);
    rs1_i = r1; rs2_i = r2; re1_i = e1; re2_i = e2;
    rd_i = rd; RegWrite_i = we; is_load_i = ld; bubble_i = 1'b0;
  endtask

  task automatic nop();
    id(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    bubble_i = 1'b1;
  endtask

  task automatic drain(input logic [31:0] k1, input logic [31:0] k2);
    for (int i = 0; i < 3; i++) begin
      nop(); want2("drain", 7'b0, k1, k2); chk(); tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; jump = 1'b0; nop();
    #1 reset = 1'b0;
    #1;
    want("reset", 1, 7'b0, 0); want("reset", 2, 7'b0, 0); want("reset", 3, 7'b0, 0);
    cmp();
    @(negedge clk); reset = 1'b1;
    tick();

    // EX forward: addi x5,x0,3 ; add x6,x5,x5
    id(5'd0, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0); want2("t1_addi", 7'b0, 0, 0); chk(); tick();
    id(5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0); want2("t1_ex_fwd", 7'b0100100, 0, 0); chk(); tick();
    nop(); want2("t1_bubble", 7'b0, 0, 0); chk(); tick();

    // Priority EX > MEM, then MEM and WB forwards
    id(5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0); want2("t2_w7a", 7'b0, 0, 0); chk(); tick();
    id(5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0); want2("t2_w7b", 7'b0, 0, 0); chk(); tick();
    id(5'd7, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0); want2("t2_ex_over_mem", 7'b0100000, 0, 0); chk(); tick();
    id(5'd0, 5'd7, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0); want2("t2_mem_fwd", 7'b0000010, 0, 0); chk(); tick();
    id(5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0); want2("t2_wb_fwd_noself", 7'b0001000, 0, 0); chk(); tick();

    // x0 never matches; re and bubble gate the compare
    id(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0); want2("t3_wx0", 7'b0, 0, 0); chk(); tick();
    id(5'd0, 5'd0, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0); want2("t3_x0", 7'b0, 0, 0); chk(); tick();
    id(5'd9, 5'd9, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0); want2("t3_re_gate", 7'b0100000, 0, 0); chk(); tick();
    id(5'd9, 5'd9, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0); bubble_i = 1'b1;
    want2("t3_bubble_gate", 7'b0, 0, 0); chk(); tick();
    drain(0, 0);

    // Load-use: lw x4,0(x1) ; add x8,x4,x2 (ID held while stalled)
    id(5'd1, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b1); want2("t4_lw", 7'b0, 0, 0); chk(); tick();
    id(5'd4, 5'd2, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0); want2("t4_stop", 7'b1000000, 0, 0); chk(); tick();
    want("t4_ls1_mem_fwd", 1, 7'b0010000, 1); want("t4_ls2_stop2", 2, 7'b1000000, 1); chk(); tick();
    want2("t4_wb_fwd", 7'b0001000, 1, 2); chk(); tick();
    drain(1, 2);

    // Younger non-load writer masks an older load
    id(5'd1, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b1); want2("t4m_lw", 7'b0, 1, 2); chk(); tick();
    id(5'd0, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0); want2("t4m_addi", 7'b0, 1, 2); chk(); tick();
    id(5'd4, 5'd0, 1'b1, 1'b0, 5'd10, 1'b1, 1'b0); want2("t4m_mask", 7'b0100000, 1, 2); chk(); tick();
    drain(1, 2);

    // Jump in the hazard cycle: no stall, ID squashed
    id(5'd1, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b1); want2("t5_lw", 7'b0, 1, 2); chk(); tick();
    id(5'd4, 5'd2, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0); jump = 1'b1;
    want2("t5_jump_nostop", 7'b0, 1, 2); chk(); tick();
    jump = 1'b0;
    id(5'd8, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0); want2("t5_ex_bubble", 7'b0, 1, 2); chk(); tick();
    drain(1, 2);

    // Reset mid-stall clears everything without a clock edge
    id(5'd1, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b1); want2("t6_lw", 7'b0, 1, 2); chk(); tick();
    id(5'd4, 5'd2, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0); want2("t6_stop", 7'b1000000, 1, 2); chk();
    #2 reset = 1'b0;
    #1;
    want2("t6_async_clear", 7'b0, 0, 0); want("t6_async_clear", 3, 7'b0, 0); cmp();
    @(posedge clk);
    @(negedge clk); reset = 1'b1;
    tick();
    want2("t6_no_fwd", 7'b0, 0, 0); chk(); tick();
    drain(0, 0);

    // Four load-use pairs: 4 stalls at LOAD_STALL=1, 8 at 2, 2-bit counter saturates at 3
    for (int i = 0; i < 4; i++) begin
      id(5'd1, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b1); tick();
      id(5'd4, 5'd2, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0); tick();
      tick();
    end
    nop();
    want2("sat", 7'b0, 4, 8); want("sat", 3, 7'b0, 3); chk();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/hazard_fwd_unit.md
Name: hazard_fwd_unit

Overview:
- Hazard-detection and operand-forwarding controller for the 5-stage RISC-V pipeline.
- Keeps its own shadow pipeline (EX/MEM/WB) of destination-register info and compares it against the source registers of the instruction in ID.
- Drives the forwarding selects and `stop` consumed by the ID/EX register, and `stop` to PC and IF/ID.
- Also squashes its shadow slot on `jump` and counts stall cycles.

Parameters:
- LOAD_STALL, 1, load-use stall cycles; legal values 1 or 2. With 2, a load result is not forwarded from MEM.
- CNT_W, 32, width of the stall performance counter.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous active-low reset
- rs1_i  input  5  ID instruction source register 1
- rs2_i  input  5  ID instruction source register 2
- re1_i  input  1  ID instruction reads rs1
- re2_i  input  1  ID instruction reads rs2
- rd_i  input  5  ID instruction destination register
- RegWrite_i  input  1  ID instruction writes rd
- is_load_i  input  1  ID instruction is a load (wD_sel selects DRAM)
- bubble_i  input  1  ID slot holds a bubble (treat as no read, no write)
- jump  input  1  branch/jump taken, resolved in EX; flushes the ID slot
- case_A1, case_B1, case_C1  output  1 each  rs1 forward from EX / MEM / WB
- case_A2, case_B2, case_C2  output  1 each  rs2 forward from EX / MEM / WB
- stop  output  1  stall: hold PC and IF/ID, insert bubble into ID/EX
- stall_cnt_o  output  CNT_W  total cycles with stop=1 (saturating)

Behaviour:
- Shadow state, one entry per stage EX, MEM, WB. Each entry holds `{valid, rd[4:0], we, load}`.
- Reset (async, reset=0):
  - all entries cleared (valid=0, we=0, load=0, rd=0);
  - stall_cnt_o=0 and the internal stall counter=0;
  - all outputs low, because the outputs are combinational from the cleared state.
- Per posedge (reset=1):
  - WB <= MEM;
  - MEM <= EX;
  - EX <= bubble if (stop | jump | bubble_i), else `{1, rd_i, RegWrite_i, is_load_i}`.
- Match rule: stage S matches source rsN iff all of the following hold:
  - S.valid and S.we;
  - S.rd != 0;
  - S.rd == rsN;
  - reN_i = 1 and bubble_i = 0.
  - x0 never matches.
- Forward selects (combinational, same cycle):
  - Priority EX > MEM > WB; at most one of A/B/C is asserted per operand.
  - case_A* is asserted only if the EX entry is not a load.
  - case_B* on a load entry is asserted only when LOAD_STALL=1.
- Load-use hazard:
  - Hazard when the EX entry matches (either operand) and has load=1.
  - When LOAD_STALL=2, a MEM entry that matches and has load=1 is also a hazard.
  - A matching higher-priority non-load younger stage masks an older load match.
- Output rule: stop = hazard & ~jump.
  - jump wins: a wrong-path ID instruction is never stalled.
  - While stop=1, all case_* outputs are 0.
- Stall duration:
  - Stall lasts until the load leaves the hazard window: 1 cycle (LOAD_STALL=1) or 2 cycles (LOAD_STALL=2).
  - This falls out naturally because bubbles are injected into EX while ID is held.
- Stall counter:
  - stall_cnt_o increments by 1 on each posedge where stop=1.
  - It saturates at all-ones and does not wrap.
- Boundary cases:
  - rs1 == rs2 == matching rd: both operands forward from the same stage.
  - rd_i == rs of the same ID instruction: no self-match; ID is never compared with itself.
  - Reset asserted mid-stall: stall ends immediately and all shadow state is cleared.
  - jump in the same cycle as a hazard: stop=0, and EX receives a bubble.

Test Plan:
1. **EX forward.** `addi x5,x0,3` followed by `add x6,x5,x5`, each RegWrite=1, bubble_i=0, re1_i=re2_i=1.
   -> In the cycle `add` is in ID: case_A1=case_A2=1, all others 0, stop=0.
2. **Priority and WB forward.**
   - Writes to x7 in EX and in MEM simultaneously, ID reads rs1=x7 -> only case_A1=1.
   - Only a WB write to x7 -> case_C1=1.
3. **x0 and re gating.**
   - Write to x0 in EX, ID rs1=0 -> no case_* asserted.
   - Write to x9 in EX, ID rs2=x9 with re2_i=0 -> case_A2=0.
4. **Load-use, LOAD_STALL=1.** `lw x4,0(x1)` followed by `add x8,x4,x2`.
   -> stop=1 for exactly 1 cycle; next cycle case_B1=1, stop=0; stall_cnt_o=1.
   - Repeat with LOAD_STALL=2 -> stop=1 for 2 cycles, then case_C1=1; stall_cnt_o=2.
5. **Jump masks stall.** Load-use condition present and jump=1 in the same cycle.
   -> stop=0; EX shadow entry is a bubble; stall_cnt_o unchanged.
6. **Reset mid-stall.** Drive reset=0 during stop=1.
   -> stop=0 and stall_cnt_o=0 immediately, without waiting for a clock edge; after release, a dependent pair with no producers in flight gives no forwarding.
